// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Generic valid/ready pipeline stage register. Carries an opaque DW-bit
//   payload between two pipeline stages with back-pressure, synchronous
//   flush and a saturating stall-cycle counter for performance analysis.
//
//   Optional feature macro: PIPE_SKID_EN
//     defined   : 2-entry buffer (output register + skid register). in_ready
//                 is a flop, so the ready path is cut between stages.
//     undefined : single entry; in_ready = !out_valid || out_ready.
//
// Parameters
//   DW       payload width in bits
//   RST_VAL  payload shown on reset, after flush and whenever empty
//   CW       stall counter width
//
// Ports
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     upstream offers in_data
//   in_ready     stage can accept (transfer on in_valid && in_ready)
//   in_data      upstream payload
//   out_valid    stage holds a payload for downstream
//   out_ready    downstream accepts (transfer on out_valid && out_ready)
//   out_data     registered payload (RST_VAL while empty)
//   flush_i      synchronous kill of all held entries
//   clr_cnt_i    synchronous clear of the stall counter (wins over increment)
//   stall_cnt_o  saturating count of cycles with out_valid && !out_ready
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   RST_VAL = {DW{1'b0}},
  parameter int              CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          flush_i,
  input  logic          clr_cnt_i,
  output logic [CW-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state_p0, state_nx;
  logic          vld_p0;
  logic [DW-1:0] data_p0, data_nx;
  logic [CW-1:0] cnt_p0;
  logic          in_xfer, out_xfer;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (&v) return v;
    else    return v + CW'(1);
  endfunction

  assign out_valid   = vld_p0;
  assign out_data    = data_p0;
  assign stall_cnt_o = cnt_p0;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = vld_p0 && out_ready;

`ifdef PIPE_SKID_EN
  logic          rdy_p0;
  logic [DW-1:0] skid_p0, skid_nx;

  // Registered ready: only depends on whether both entries are occupied.
  assign in_ready = rdy_p0;
`else
  assign in_ready = !vld_p0 || out_ready;
`endif

  always_comb begin
    state_nx = state_p0;
    data_nx  = data_p0;
`ifdef PIPE_SKID_EN
    skid_nx  = skid_p0;
`endif
    if (flush_i) begin
      // Any input accepted this cycle is dropped; the skid entry is
      // invalidated simply by leaving TWO.
      state_nx = EMPTY;
      data_nx  = RST_VAL;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (in_xfer) begin
            state_nx = ONE;
            data_nx  = in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            data_nx = in_data;
          end else if (out_xfer) begin
            state_nx = EMPTY;
            data_nx  = RST_VAL;
          end
`ifdef PIPE_SKID_EN
          else if (in_xfer) begin
            // Downstream stalled: park the new payload behind the output.
            state_nx = TWO;
            skid_nx  = in_data;
          end
`endif
        end
`ifdef PIPE_SKID_EN
        TWO: begin
          if (out_xfer) begin
            state_nx = ONE;
            data_nx  = skid_p0;
          end
        end
`endif
        default: begin
          state_nx = EMPTY;
          data_nx  = RST_VAL;
        end
      endcase
    end
  end

  // ---- stage p0: output register and occupancy ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= EMPTY;
      vld_p0   <= 1'b0;
      data_p0  <= RST_VAL;
    end else begin
      state_p0 <= state_nx;
      vld_p0   <= (state_nx != EMPTY);
      data_p0  <= data_nx;
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_p0 <= 1'b1;
    else        rdy_p0 <= (state_nx != TWO);
  end

  // Skid payload is only meaningful in TWO, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_p0 <= skid_nx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt_p0 <= '0;
    else if (clr_cnt_i)             cnt_p0 <= '0;
    else if (vld_p0 && !out_ready)  cnt_p0 <= sat_inc(cnt_p0);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int            DW   = 8;
  localparam int            CW   = 2;
  localparam logic [DW-1:0] RV   = 8'h5A;
  localparam logic [CW-1:0] CMAX = '1;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk, rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic          flush_i, clr_cnt_i;
  logic [CW-1:0] stall_cnt_o;

  pipe_stage_reg #(.DW(DW), .RST_VAL(RV), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush_i(flush_i), .clr_cnt_i(clr_cnt_i), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          fl;
    logic          clr;
    logic          chk;
    logic          e_vld;
    logic [DW-1:0] e_data;
    logic          e_rdy;
    logic [CW-1:0] e_cnt;
  } vec_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] q[$];
  logic [CW-1:0] m_cnt;
  vec_t          tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] id, input logic ordy,
                              input logic fl, input logic clr, input logic chk,
                              input logic ev, input logic [DW-1:0] ed, input logic er,
                              input logic [CW-1:0] ec);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl; v.clr = clr; v.chk = chk;
    v.e_vld = ev; v.e_data = ed; v.e_rdy = er; v.e_cnt = ec;
    return v;
  endfunction

  // One clock cycle: drive at negedge, check handshake against the queue
  // model, update scoreboard, then check registered outputs after the edge.
  task automatic step(input vec_t v);
    logic exp_rdy, in_x, out_x, stall;
    @(negedge clk);
    in_valid = v.iv; in_data = v.id; out_ready = v.ordy;
    flush_i = v.fl;  clr_cnt_i = v.clr;
    #1;
    exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || v.ordy);
    check("in_ready_pre", 32'(in_ready), 32'(exp_rdy));
    in_x  = v.iv && exp_rdy;
    out_x = (q.size() != 0) && v.ordy;
    stall = (q.size() != 0) && !v.ordy;
    if (out_x) void'(q.pop_front());
    if (v.fl) q.delete();
    else if (in_x) q.push_back(v.id);
    if (v.clr) m_cnt = '0;
    else if (stall && m_cnt != CMAX) m_cnt = m_cnt + 1'b1;
    @(posedge clk);
    #1;
    check("sb_out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("sb_out_data", 32'(out_data), 32'((q.size() != 0) ? q[0] : RV));
    check("sb_stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
    if (v.chk) begin
      check("vec_out_valid", 32'(out_valid), 32'(v.e_vld));
      check("vec_out_data", 32'(out_data), 32'(v.e_data));
      check("vec_in_ready", 32'(in_ready), 32'(v.e_rdy));
      check("vec_stall_cnt", 32'(stall_cnt_o), 32'(v.e_cnt));
    end
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush_i = 1'b0; clr_cnt_i = 1'b0; rst_n = 1'b0;
    m_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(RV));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_stall_cnt", 32'(stall_cnt_o), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with out_ready held high.
    tbl.push_back(mk(1, 8'h01, 1, 0, 0, 1, 1, 8'h01, 1, 0));
    tbl.push_back(mk(1, 8'h02, 1, 0, 0, 1, 1, 8'h02, 1, 0));
    tbl.push_back(mk(1, 8'h03, 1, 0, 0, 1, 1, 8'h03, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, RV,    1, 0));
    if (SKID) begin
      // Back-pressure: both entries fill, third offer refused.
      tbl.push_back(mk(1, 8'h0A, 0, 0, 0, 1, 1, 8'h0A, 1, 0));
      tbl.push_back(mk(1, 8'h0B, 0, 0, 0, 1, 1, 8'h0A, 0, 1));
      tbl.push_back(mk(1, 8'h0C, 0, 0, 0, 1, 1, 8'h0A, 0, 2));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 8'h0B, 1, 2));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, RV,    1, 2));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, RV,    1, 0));
      // Flush with two entries held and 0x0C offered.
      tbl.push_back(mk(1, 8'h0A, 0, 0, 0, 1, 1, 8'h0A, 1, 0));
      tbl.push_back(mk(1, 8'h0B, 0, 0, 0, 1, 1, 8'h0A, 0, 1));
      tbl.push_back(mk(1, 8'h0C, 0, 1, 0, 1, 0, RV,    1, 2));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, RV,    1, 0));
    end else begin
      // Back-pressure: 0x0B waits until 0x0A leaves.
      tbl.push_back(mk(1, 8'h0A, 0, 0, 0, 1, 1, 8'h0A, 0, 0));
      tbl.push_back(mk(1, 8'h0B, 0, 0, 0, 1, 1, 8'h0A, 0, 1));
      tbl.push_back(mk(1, 8'h0B, 1, 0, 0, 1, 1, 8'h0B, 1, 1));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, RV,    1, 1));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, RV,    1, 0));
      // Flush: 0x0C handshakes but is discarded.
      tbl.push_back(mk(1, 8'h0A, 0, 0, 0, 1, 1, 8'h0A, 0, 0));
      tbl.push_back(mk(1, 8'h0C, 1, 1, 0, 1, 0, RV,    1, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, RV,    1, 0));
    end
    // Stall counter saturation at CW=2, then clear wins over increment.
    tbl.push_back(mk(1, 8'h0D, 0, 0, 0, 1, 1, 8'h0D, SKID, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 8'h0D, SKID, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 8'h0D, SKID, 2));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 8'h0D, SKID, 3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 8'h0D, SKID, 3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 8'h0D, SKID, 3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 1, 8'h0D, SKID, 3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 8'h0D, SKID, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, RV,    1, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Reset mid-operation: outputs must clear before the next edge.
    step(mk(1, 8'hE1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 8'hE2, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hE3; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_out_data", 32'(out_data), 32'(RV));
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    check("mid_rst_stall_cnt", 32'(stall_cnt_o), 32'(0));
    q.delete();
    m_cnt = '0;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Random valid/ready traffic with occasional flush and clear.
    for (int i = 0; i < 10000; i++) begin
      step(mk(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 99) < 60),
              1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 63) == 0),
              0, 0, 0, 0, 0));
    end
    // Drain: everything accepted must come out.
    repeat (4) step(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0));
    check("drain_empty", 32'(q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
